// File: rtl/fadd_arbiter.sv
// fadd_arbiter: two requesters share one single-precision fadd datapath.
// A three-state FSM (IDLE/CALC/DONE) accepts one operation at a time,
// waits LATENCY cycles, and holds the result until the consumer takes it.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake for requester N (0,1)
//   reqN_a, reqN_b, reqN_sub    IEEE-754 operands, sub selects a-b
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_result          owning requester and sum/difference
//   busy                        high whenever the FSM is not IDLE
//
// Build option: define FADD_ARBITER_ROUND_ROBIN_EN for alternating grant on
// ties. Left undefined, requester 0 always wins ties.

module fadd_arbiter_fadd (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    // Round-to-nearest-even adder; subnormal inputs and results flush to zero.
    logic [31:0]       w_x, w_y;      // w_x has the larger magnitude
    logic [7:0]        w_ex, w_ey, w_d;
    logic [26:0]       w_mx, w_my, w_my_sh, w_n;
    logic [27:0]       w_s;
    logic [4:0]        w_lz;
    logic signed [9:0] w_e;
    logic [24:0]       w_m;
    logic              w_round;

    always_comb begin
        if (i_a[30:0] >= i_b[30:0]) {w_x, w_y} = {i_a, i_b};
        else                        {w_x, w_y} = {i_b, i_a};
        w_ex = w_x[30:23];
        w_ey = w_y[30:23];
        // Hidden bit, 23 fraction bits, then guard/round/sticky positions.
        w_mx = (w_ex == 8'd0) ? 27'd0 : {1'b1, w_x[22:0], 3'b000};
        w_my = (w_ey == 8'd0) ? 27'd0 : {1'b1, w_y[22:0], 3'b000};
        w_d  = w_ex - w_ey;
        if (w_d > 8'd26) begin
            w_my_sh = {26'd0, |w_my};
        end else begin
            w_my_sh = w_my >> w_d;
            // Any bit lost by the alignment shift becomes the sticky bit.
            if ((w_my_sh << w_d) != w_my) w_my_sh[0] = 1'b1;
        end
        if (w_x[31] == w_y[31]) w_s = {1'b0, w_mx} + {1'b0, w_my_sh};
        else                    w_s = {1'b0, w_mx} - {1'b0, w_my_sh};

        w_lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (w_s[i]) w_lz = 5'(26 - i);
        end
        w_e = {2'b00, w_ex};
        if (w_s[27]) begin
            w_n = w_s[27:1] | {26'd0, w_s[0]};
            w_e = w_e + 10'sd1;
        end else begin
            w_n = w_s[26:0] << w_lz;
            w_e = w_e - $signed({5'd0, w_lz});
        end
        w_round = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_m     = {1'b0, w_n[26:3]} + {24'd0, w_round};
        if (w_m[24]) w_e = w_e + 10'sd1;   // rounding carried into a new binade

        o_sum = 32'd0;
        if (w_ex == 8'hFF) begin
            // NaN in, or infinities of opposite sign, give the canonical qNaN.
            if (w_x[22:0] != 23'd0 || (w_ey == 8'hFF && w_x[31] != w_y[31]))
                o_sum = 32'h7FC0_0000;
            else
                o_sum = w_x;
        end else if (w_s == 28'd0) begin
            o_sum = 32'd0;                  // exact cancellation gives +0
        end else if (w_e <= 10'sd0) begin
            o_sum = {w_x[31], 31'd0};
        end else if (w_e >= 10'sd255) begin
            o_sum = {w_x[31], 8'hFF, 23'd0};
        end else begin
            o_sum = {w_x[31], w_e[7:0], w_m[22:0]};
        end
    end
endmodule

module fadd_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    input  logic        rsp_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_a, r_b;
    logic        r_sub, r_id;
    logic        r_rsp_valid, r_rsp_id;
    logic [31:0] r_rsp_result;
    logic        w_grant0, w_grant1, w_accept;
    logic [31:0] w_b_eff, w_sum;

`ifdef FADD_ARBITER_ROUND_ROBIN_EN
    logic r_last_grant;
    // On a tie, the requester that did not win last time gets the grant.
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
`else
    assign w_grant1 = req1_valid && !req0_valid;
`endif
    assign w_grant0 = req0_valid && !w_grant1;

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign req0_ready = reset && (r_state == IDLE) && w_grant0;
    assign req1_ready = reset && (r_state == IDLE) && w_grant1;
    assign w_accept   = (r_state == IDLE) && (req0_valid || req1_valid);

    // Subtraction is addition with the latched b sign flipped.
    assign w_b_eff = r_sub ? {~r_b[31], r_b[30:0]} : r_b;

    fadd_arbiter_fadd u_fadd (
        .i_a   (r_a),
        .i_b   (w_b_eff),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= 32'd0;
`ifdef FADD_ARBITER_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant1 ? req1_a   : req0_a;
                        r_b     <= w_grant1 ? req1_b   : req0_b;
                        r_sub   <= w_grant1 ? req1_sub : req0_sub;
                        r_id    <= w_grant1;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= CALC;
`ifdef FADD_ARBITER_ROUND_ROBIN_EN
                        r_last_grant <= w_grant1;
`endif
                    end
                end
                CALC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_result <= w_sum;
                        r_rsp_id     <= r_id;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = (r_state != IDLE);
endmodule
